// File: rtl/branch_recovery_pkg.sv
// Shared types for the branch recovery slice: recovery FSM states and the
// per-ROB-slot resolution record.
package branch_recovery_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } br_rec_state_t;

  typedef struct packed {
    logic        v;
    logic        mis;
    logic        taken;
    logic [31:0] act_next;
    logic [31:0] target;
    logic [31:0] pc;
  } br_res_entry_t;

  // Fall-through wraps at 2^32 like any other fetch address.
  function automatic logic [31:0] calc_act_next(input logic        taken,
                                                input logic [31:0] target,
                                                input logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_res_table.sv
// ROB-indexed resolution table: one write port, one combinational read port
// that forwards a same-cycle write, a per-index clear and a global clear.
module br_res_table
  import branch_recovery_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  br_res_entry_t wr_data,
  input  logic          clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic          clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output br_res_entry_t rd_data
);

  br_res_entry_t table_q [DEPTH];
  br_res_entry_t table_d [DEPTH];

  // A commit that consumes a bypassed write leaves the slot invalid, so the
  // clears are applied after the write.
  always_comb begin
    table_d = table_q;
    if (wr_en) table_d[wr_idx] = wr_data;
    if (clr_en) table_d[clr_idx].v = 1'b0;
    if (clr_all) begin
      for (int i = 0; i < DEPTH; i++) table_d[i].v = 1'b0;
    end
  end

  always_comb begin
    rd_data = table_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_data = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/branch_recovery.sv
// Consumes branch-unit resolutions, gates ROB commit of branches, releases
// predictor updates and sequences the flush/redirect after a mispredict.
module branch_recovery
  import branch_recovery_pkg::*;
#(
  parameter int ROB_DEPTH    = 16,
  parameter int ROB_IDX_W    = $clog2(ROB_DEPTH),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [ROB_IDX_W-1:0] br_rob_idx,
  input  logic [31:0]          br_pc,
  input  logic [31:0]          br_pred_next,
  input  logic                 br_result,
  input  logic [31:0]          br_target,
  output logic                 stall_br,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx,
  input  logic                 commit_is_br,
  output logic                 commit_ready,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 bp_upd_valid,
  output logic [31:0]          bp_upd_pc,
  output logic                 bp_upd_taken,
  output logic [31:0]          bp_upd_target,
  output logic [31:0]          perf_br_cnt,
  output logic [31:0]          perf_mispred_cnt
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  br_rec_state_t  state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic           stall_q, stall_d;
  logic           flush_q, flush_d;
  logic [31:0]    redirect_pc_q, redirect_pc_d;
  logic           bp_upd_valid_q, bp_upd_valid_d;
  logic [31:0]    bp_upd_pc_q, bp_upd_pc_d;
  logic           bp_upd_taken_q, bp_upd_taken_d;
  logic [31:0]    bp_upd_target_q, bp_upd_target_d;
  logic [31:0]    br_cnt_q, br_cnt_d;
  logic [31:0]    mis_cnt_q, mis_cnt_d;

  logic           idle;
  logic           wr_en;
  logic [31:0]    res_act_next;
  br_res_entry_t  wr_data;
  br_res_entry_t  rd_data;
  logic           br_commit;

  // Anything resolving outside IDLE is younger than the flushing branch.
  always_comb begin
    idle         = (state_q == IDLE);
    wr_en        = br_valid && idle;
    res_act_next = calc_act_next(br_result, br_target, br_pc);
    wr_data      = '{v: 1'b1, mis: (res_act_next != br_pred_next),
                     taken: br_result, act_next: res_act_next,
                     target: br_target, pc: br_pc};
    commit_ready = idle && (!commit_is_br || rd_data.v);
    br_commit    = commit_valid && commit_is_br && commit_ready;
  end

  br_res_table #(
    .DEPTH (ROB_DEPTH),
    .IDX_W (ROB_IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (br_rob_idx),
    .wr_data (wr_data),
    .clr_en  (br_commit),
    .clr_idx (commit_rob_idx),
    .clr_all (state_q == FLUSH),
    .rd_idx  (commit_rob_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    stall_d         = stall_q;
    flush_d         = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    bp_upd_valid_d  = 1'b0;
    bp_upd_pc_d     = bp_upd_pc_q;
    bp_upd_taken_d  = bp_upd_taken_q;
    bp_upd_target_d = bp_upd_target_q;
    br_cnt_d        = br_cnt_q;
    mis_cnt_d       = mis_cnt_q;
    case (state_q)
      IDLE: begin
        if (br_commit) begin
          bp_upd_valid_d  = 1'b1;
          bp_upd_pc_d     = rd_data.pc;
          bp_upd_taken_d  = rd_data.taken;
          bp_upd_target_d = rd_data.target;
          br_cnt_d        = br_cnt_q + 32'd1;
          if (rd_data.mis) begin
            mis_cnt_d     = mis_cnt_q + 32'd1;
            redirect_pc_d = rd_data.act_next;
            flush_d       = 1'b1;
            stall_d       = 1'b1;
            state_d       = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d     = DRAIN;
        drain_cnt_d = DRAIN_LOAD;
        stall_d     = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = IDLE;
          stall_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      drain_cnt_q     <= '0;
      stall_q         <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      bp_upd_valid_q  <= 1'b0;
      bp_upd_pc_q     <= '0;
      bp_upd_taken_q  <= 1'b0;
      bp_upd_target_q <= '0;
      br_cnt_q        <= '0;
      mis_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      stall_q         <= stall_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      bp_upd_valid_q  <= bp_upd_valid_d;
      bp_upd_pc_q     <= bp_upd_pc_d;
      bp_upd_taken_q  <= bp_upd_taken_d;
      bp_upd_target_q <= bp_upd_target_d;
      br_cnt_q        <= br_cnt_d;
      mis_cnt_q       <= mis_cnt_d;
    end
  end

  assign stall_br         = stall_q;
  assign flush            = flush_q;
  assign redirect_valid   = flush_q;
  assign redirect_pc      = redirect_pc_q;
  assign bp_upd_valid     = bp_upd_valid_q;
  assign bp_upd_pc        = bp_upd_pc_q;
  assign bp_upd_taken     = bp_upd_taken_q;
  assign bp_upd_target    = bp_upd_target_q;
  assign perf_br_cnt      = br_cnt_q;
  assign perf_mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_recovery.sv
// Directed bench for branch_recovery: a per-slot reference model compared
// every cycle, plus hand-computed expectations for each scenario.
module tb_branch_recovery;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_valid;
  logic [3:0]  br_rob_idx;
  logic [31:0] br_pc;
  logic [31:0] br_pred_next;
  logic        br_result;
  logic [31:0] br_target;
  logic        stall_br;
  logic        commit_valid;
  logic [3:0]  commit_rob_idx;
  logic        commit_is_br;
  logic        commit_ready;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_upd_valid;
  logic [31:0] bp_upd_pc;
  logic        bp_upd_taken;
  logic [31:0] bp_upd_target;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_recovery #(
    .ROB_DEPTH    (16),
    .ROB_IDX_W    (4),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .br_valid         (br_valid),
    .br_rob_idx       (br_rob_idx),
    .br_pc            (br_pc),
    .br_pred_next     (br_pred_next),
    .br_result        (br_result),
    .br_target        (br_target),
    .stall_br         (stall_br),
    .commit_valid     (commit_valid),
    .commit_rob_idx   (commit_rob_idx),
    .commit_is_br     (commit_is_br),
    .commit_ready     (commit_ready),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .bp_upd_valid     (bp_upd_valid),
    .bp_upd_pc        (bp_upd_pc),
    .bp_upd_taken     (bp_upd_taken),
    .bp_upd_target    (bp_upd_target),
    .perf_br_cnt      (perf_br_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: resolved-branch records per ROB slot and the number of
  // cycles of recovery still owed (flush cycle plus drain cycles).
  bit          m_v     [16];
  bit          m_mis   [16];
  bit          m_taken [16];
  logic [31:0] m_act   [16];
  logic [31:0] m_pc    [16];
  logic [31:0] m_tgt   [16];
  int          m_recover;
  bit          exp_flush;
  logic [31:0] exp_redirect;
  bit          exp_bp_valid;
  bit          exp_bp_taken;
  logic [31:0] exp_bp_pc;
  logic [31:0] exp_bp_tgt;
  logic [31:0] exp_br_cnt;
  logic [31:0] exp_mis_cnt;

  always @(posedge clk or posedge rst) begin
    bit          hit;
    bit          do_commit;
    bit          c_mis;
    bit          c_taken;
    logic [31:0] r_act;
    logic [31:0] c_act;
    logic [31:0] c_pc;
    logic [31:0] c_tgt;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      m_recover    = 0;
      exp_flush    = 1'b0;
      exp_redirect = 32'd0;
      exp_bp_valid = 1'b0;
      exp_bp_taken = 1'b0;
      exp_bp_pc    = 32'd0;
      exp_bp_tgt   = 32'd0;
      exp_br_cnt   = 32'd0;
      exp_mis_cnt  = 32'd0;
    end else begin
      exp_bp_valid = 1'b0;
      exp_flush    = 1'b0;
      if (m_recover == 0) begin
        r_act     = br_result ? br_target : br_pc + 32'd4;
        hit       = br_valid && (br_rob_idx == commit_rob_idx);
        do_commit = commit_valid && commit_is_br && (m_v[commit_rob_idx] || hit);
        if (hit) begin
          c_act = r_act; c_pc = br_pc; c_tgt = br_target;
          c_taken = br_result; c_mis = (r_act != br_pred_next);
        end else begin
          c_act = m_act[commit_rob_idx]; c_pc = m_pc[commit_rob_idx];
          c_tgt = m_tgt[commit_rob_idx]; c_taken = m_taken[commit_rob_idx];
          c_mis = m_mis[commit_rob_idx];
        end
        if (br_valid) begin
          m_v[br_rob_idx]     = 1'b1;
          m_mis[br_rob_idx]   = (r_act != br_pred_next);
          m_taken[br_rob_idx] = br_result;
          m_act[br_rob_idx]   = r_act;
          m_pc[br_rob_idx]    = br_pc;
          m_tgt[br_rob_idx]   = br_target;
        end
        if (do_commit) begin
          m_v[commit_rob_idx] = 1'b0;
          exp_bp_valid = 1'b1;
          exp_bp_pc    = c_pc;
          exp_bp_taken = c_taken;
          exp_bp_tgt   = c_tgt;
          exp_br_cnt   = exp_br_cnt + 32'd1;
          if (c_mis) begin
            exp_mis_cnt  = exp_mis_cnt + 32'd1;
            exp_flush    = 1'b1;
            exp_redirect = c_act;
            m_recover    = 1 + FLUSH_CYCLES;
          end
        end
      end else begin
        if (m_recover == 1 + FLUSH_CYCLES) begin
          for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        end
        m_recover--;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit exp_ready;
    if (!rst) begin
      exp_ready = (m_recover == 0) &&
                  (!commit_is_br || m_v[commit_rob_idx] ||
                   (br_valid && (br_rob_idx == commit_rob_idx)));
      check_output("cyc_stall_br", stall_br, (m_recover != 0));
      check_output("cyc_flush", flush, exp_flush);
      check_output("cyc_redirect_valid", redirect_valid, exp_flush);
      check_output("cyc_redirect_pc", redirect_pc, exp_redirect);
      check_output("cyc_commit_ready", commit_ready, exp_ready);
      check_output("cyc_bp_upd_valid", bp_upd_valid, exp_bp_valid);
      if (exp_bp_valid) begin
        check_output("cyc_bp_upd_pc", bp_upd_pc, exp_bp_pc);
        check_output("cyc_bp_upd_taken", bp_upd_taken, exp_bp_taken);
        check_output("cyc_bp_upd_target", bp_upd_target, exp_bp_tgt);
      end
      check_output("cyc_perf_br", perf_br_cnt, exp_br_cnt);
      check_output("cyc_perf_mis", perf_mispred_cnt, exp_mis_cnt);
    end
  end

  task automatic idle_inputs();
    br_valid = 1'b0; br_rob_idx = 4'd0; br_pc = 32'd0; br_pred_next = 32'd0;
    br_result = 1'b0; br_target = 32'd0;
    commit_valid = 1'b0; commit_rob_idx = 4'd0; commit_is_br = 1'b0;
  endtask

  task automatic apply_stimulus(input logic bv, input logic [3:0] bidx,
                                input logic [31:0] bpc, input logic [31:0] bpred,
                                input logic bres, input logic [31:0] btgt,
                                input logic cv, input logic [3:0] cidx,
                                input logic cbr);
    br_valid = bv; br_rob_idx = bidx; br_pc = bpc; br_pred_next = bpred;
    br_result = bres; br_target = btgt;
    commit_valid = cv; commit_rob_idx = cidx; commit_is_br = cbr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          stalls;
    logic [31:0] pc;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_output("rst_stall_br", stall_br, 0);
    check_output("rst_flush", flush, 0);
    check_output("rst_perf_br", perf_br_cnt, 0);
    check_output("rst_ready_nonbr", commit_ready, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd0, 1);
    #1;
    check_output("rst_ready_br", commit_ready, 0);
    idle_inputs();
    rst = 1'b0;
    step();

    $display("[TB] correct not-taken branch");
    apply_stimulus(1, 4'd3, 32'h100, 32'h104, 0, 32'h0, 0, 0, 0);
    step();
    idle_inputs();
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd3, 1);
    #1;
    check_output("t1_ready", commit_ready, 1);
    step();
    idle_inputs();
    check_output("t1_bp_valid", bp_upd_valid, 1);
    check_output("t1_bp_taken", bp_upd_taken, 0);
    check_output("t1_bp_pc", bp_upd_pc, 32'h100);
    check_output("t1_flush", flush, 0);
    check_output("t1_perf_br", perf_br_cnt, 1);
    step();

    $display("[TB] taken mispredict");
    apply_stimulus(1, 4'd5, 32'h200, 32'h204, 1, 32'h180, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 1);
    #1;
    check_output("t2_ready", commit_ready, 1);
    step();
    idle_inputs();
    check_output("t2_flush", flush, 1);
    check_output("t2_redirect_valid", redirect_valid, 1);
    check_output("t2_redirect_pc", redirect_pc, 32'h180);
    check_output("t2_perf_mis", perf_mispred_cnt, 1);
    check_output("t2_bp_target", bp_upd_target, 32'h180);
    stalls = stall_br ? 1 : 0;
    step();
    check_output("t2_flush_1cyc", flush, 0);
    for (int k = 0; k < 8 && stall_br; k++) begin
      stalls++;
      step();
    end
    check_output("t2_stall_len", stalls, 1 + FLUSH_CYCLES);

    $display("[TB] commit before resolve");
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, 1);
    #1;
    check_output("t3_ready_wait", commit_ready, 0);
    apply_stimulus(1, 4'd7, 32'h300, 32'h304, 0, 32'h0, 1, 4'd7, 1);
    #1;
    check_output("t3_ready_bypass", commit_ready, 1);
    step();
    idle_inputs();
    check_output("t3_perf_br", perf_br_cnt, 3);
    check_output("t3_bp_pc", bp_upd_pc, 32'h300);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, 1);
    #1;
    check_output("t3_ready_consumed", commit_ready, 0);
    idle_inputs();
    step();

    $display("[TB] resolves dropped during recovery");
    apply_stimulus(1, 4'd2, 32'h400, 32'h500, 0, 32'h0, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd2, 1);
    step();
    apply_stimulus(1, 4'd9, 32'h600, 32'h604, 0, 32'h0, 0, 0, 0);
    #1;
    check_output("t4_flush", flush, 1);
    check_output("t4_redirect_pc", redirect_pc, 32'h404);
    step();
    check_output("t4_drain_stall", stall_br, 1);
    step();
    step();
    idle_inputs();
    check_output("t4_idle", stall_br, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd9, 1);
    #1;
    check_output("t4_ready_dropped", commit_ready, 0);
    idle_inputs();
    step();

    rst = 1'b1;
    #1;
    check_output("rst2_perf_br", perf_br_cnt, 0);
    step();
    rst = 1'b0;
    step();

    $display("[TB] wrap and recycle");
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 0; j <= 16; j++) begin
        pc = (j == 15) ? 32'hFFFF_FFFC : 32'h1000 + 32'(j * 16);
        apply_stimulus(j < 16, 4'(j), pc, pc + 32'd4, 0, 32'h0,
                       j > 0, 4'(j - 1), 1);
        #1;
        if (j > 0) check_output("t5_ready", commit_ready, 1);
        step();
      end
    end
    idle_inputs();
    step();
    check_output("t5_perf_br", perf_br_cnt, 32);
    check_output("t5_perf_mis", perf_mispred_cnt, 0);
    check_output("t5_flush", flush, 0);

    $display("[TB] async reset mid-drain");
    apply_stimulus(1, 4'd1, 32'h700, 32'h704, 1, 32'h800, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd1, 1);
    step();
    idle_inputs();
    step();
    check_output("t6_in_drain", stall_br, 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_stall_br", stall_br, 0);
    check_output("t6_flush", flush, 0);
    check_output("t6_redirect_valid", redirect_valid, 0);
    check_output("t6_redirect_pc", redirect_pc, 0);
    check_output("t6_bp_valid", bp_upd_valid, 0);
    check_output("t6_perf_br", perf_br_cnt, 0);
    check_output("t6_perf_mis", perf_mispred_cnt, 0);
    check_output("t6_ready_nonbr", commit_ready, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd1, 1);
    #1;
    check_output("t6_ready_br", commit_ready, 0);
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    check_output("t6_idle_after", stall_br, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
